bsg_axil_rw_serializer: RTL and testbench



---
 rtl/bsg_axil_pkg.sv | 13 +
 rtl/bsg_axil_rw_serializer.sv | 160 ++++++++++++++++
 tb/tb_bsg_axil_rw_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_axil_pkg.sv
// rtl/bsg_axil_pkg.sv - shared AXI-lite types and response codes
package bsg_axil_pkg;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eRead  = 2'd1,
    eWrite = 2'd2
  } bsg_axil_rw_state_e;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

endpackage

// File: rtl/bsg_axil_rw_serializer.sv
// rtl/bsg_axil_rw_serializer.sv - one-at-a-time AXI-lite read/write serializer
module bsg_axil_rw_serializer
  import bsg_axil_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [addr_width_p-1:0]     s00_axil_awaddr,
  input  logic [2:0]                  s00_axil_awprot,
  input  logic                        s00_axil_awvalid,
  output logic                        s00_axil_awready,
  input  logic [data_width_p-1:0]     s00_axil_wdata,
  input  logic [data_width_p/8-1:0]   s00_axil_wstrb,
  input  logic                        s00_axil_wvalid,
  output logic                        s00_axil_wready,
  output logic [1:0]                  s00_axil_bresp,
  output logic                        s00_axil_bvalid,
  input  logic                        s00_axil_bready,
  input  logic [addr_width_p-1:0]     s00_axil_araddr,
  input  logic [2:0]                  s00_axil_arprot,
  input  logic                        s00_axil_arvalid,
  output logic                        s00_axil_arready,
  output logic [data_width_p-1:0]     s00_axil_rdata,
  output logic [1:0]                  s00_axil_rresp,
  output logic                        s00_axil_rvalid,
  input  logic                        s00_axil_rready,

  output logic [addr_width_p-1:0]     m00_axil_awaddr,
  output logic [2:0]                  m00_axil_awprot,
  output logic                        m00_axil_awvalid,
  input  logic                        m00_axil_awready,
  output logic [data_width_p-1:0]     m00_axil_wdata,
  output logic [data_width_p/8-1:0]   m00_axil_wstrb,
  output logic                        m00_axil_wvalid,
  input  logic                        m00_axil_wready,
  input  logic [1:0]                  m00_axil_bresp,
  input  logic                        m00_axil_bvalid,
  output logic                        m00_axil_bready,
  output logic [addr_width_p-1:0]     m00_axil_araddr,
  output logic [2:0]                  m00_axil_arprot,
  output logic                        m00_axil_arvalid,
  input  logic                        m00_axil_arready,
  input  logic [data_width_p-1:0]     m00_axil_rdata,
  input  logic [1:0]                  m00_axil_rresp,
  input  logic                        m00_axil_rvalid,
  output logic                        m00_axil_rready
);

  bsg_axil_rw_state_e state_q, state_d;
  logic ar_sent_q, ar_sent_d;
  logic aw_sent_q, aw_sent_d;
  logic w_sent_q, w_sent_d;
  logic last_wr_q, last_wr_d;

  // Payloads pass straight through; only the handshakes are gated.
  assign m00_axil_awaddr = s00_axil_awaddr;
  assign m00_axil_awprot = s00_axil_awprot;
  assign m00_axil_wdata  = s00_axil_wdata;
  assign m00_axil_wstrb  = s00_axil_wstrb;
  assign m00_axil_araddr = s00_axil_araddr;
  assign m00_axil_arprot = s00_axil_arprot;
  assign s00_axil_bresp  = m00_axil_bresp;
  assign s00_axil_rdata  = m00_axil_rdata;
  assign s00_axil_rresp  = m00_axil_rresp;

  // State and per-channel sent flags; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= eIdle;
      ar_sent_q <= 1'b0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ar_sent_q <= ar_sent_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Round-robin grant in idle, then gate handshakes of the granted channel.
  always_comb begin
    state_d          = state_q;
    ar_sent_d        = ar_sent_q;
    aw_sent_d        = aw_sent_q;
    w_sent_d         = w_sent_q;
    last_wr_d        = last_wr_q;
    s00_axil_awready = 1'b0;
    s00_axil_wready  = 1'b0;
    s00_axil_bvalid  = 1'b0;
    s00_axil_arready = 1'b0;
    s00_axil_rvalid  = 1'b0;
    m00_axil_awvalid = 1'b0;
    m00_axil_wvalid  = 1'b0;
    m00_axil_bready  = 1'b0;
    m00_axil_arvalid = 1'b0;
    m00_axil_rready  = 1'b0;

    case (state_q)
      eIdle: begin
        // A read wins a tie only when the previous grant went to a write.
        if (s00_axil_arvalid && (!s00_axil_awvalid || last_wr_q)) begin
          state_d   = eRead;
          last_wr_d = 1'b0;
        end else if (s00_axil_awvalid) begin
          state_d   = eWrite;
          last_wr_d = 1'b1;
        end
      end

      eRead: begin
        m00_axil_arvalid = s00_axil_arvalid & ~ar_sent_q;
        s00_axil_arready = m00_axil_arready & ~ar_sent_q;
        if (s00_axil_arvalid && m00_axil_arready && !ar_sent_q) begin
          ar_sent_d = 1'b1;
        end
        s00_axil_rvalid = m00_axil_rvalid & ar_sent_q;
        m00_axil_rready = s00_axil_rready & ar_sent_q;
        if (m00_axil_rvalid && s00_axil_rready && ar_sent_q) begin
          state_d   = eIdle;
          ar_sent_d = 1'b0;
        end
      end

      eWrite: begin
        m00_axil_awvalid = s00_axil_awvalid & ~aw_sent_q;
        s00_axil_awready = m00_axil_awready & ~aw_sent_q;
        if (s00_axil_awvalid && m00_axil_awready && !aw_sent_q) begin
          aw_sent_d = 1'b1;
        end
        m00_axil_wvalid = s00_axil_wvalid & ~w_sent_q;
        s00_axil_wready = m00_axil_wready & ~w_sent_q;
        if (s00_axil_wvalid && m00_axil_wready && !w_sent_q) begin
          w_sent_d = 1'b1;
        end
        // A response arriving before both halves are sent is held off.
        s00_axil_bvalid = m00_axil_bvalid & aw_sent_q & w_sent_q;
        m00_axil_bready = s00_axil_bready & aw_sent_q & w_sent_q;
        if (m00_axil_bvalid && s00_axil_bready && aw_sent_q && w_sent_q) begin
          state_d   = eIdle;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
        end
      end

      default: begin
        state_d   = eIdle;
        ar_sent_d = 1'b0;
        aw_sent_d = 1'b0;
        w_sent_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bsg_axil_rw_serializer.sv
// tb/tb_bsg_axil_rw_serializer.sv - directed bench for bsg_axil_rw_serializer
module tb_bsg_axil_rw_serializer;
  import bsg_axil_pkg::*;

  localparam int aw_lp = 32;
  localparam int dw_lp = 32;

  logic clk, reset_n;
  logic [aw_lp-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [2:0] s_awprot, s_arprot, m_awprot, m_arprot;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [dw_lp-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [dw_lp/8-1:0] s_wstrb, m_wstrb;
  logic [1:0] s_bresp, s_rresp, m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  int errors = 0;
  int checks = 0;
  logic overlap_seen = 1'b0;
  logic [9:0] vr_out;

  assign vr_out = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                   m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

  bsg_axil_rw_serializer #(.addr_width_p(aw_lp), .data_width_p(dw_lp)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s00_axil_awaddr(s_awaddr), .s00_axil_awprot(s_awprot), .s00_axil_awvalid(s_awvalid),
    .s00_axil_awready(s_awready), .s00_axil_wdata(s_wdata), .s00_axil_wstrb(s_wstrb),
    .s00_axil_wvalid(s_wvalid), .s00_axil_wready(s_wready), .s00_axil_bresp(s_bresp),
    .s00_axil_bvalid(s_bvalid), .s00_axil_bready(s_bready), .s00_axil_araddr(s_araddr),
    .s00_axil_arprot(s_arprot), .s00_axil_arvalid(s_arvalid), .s00_axil_arready(s_arready),
    .s00_axil_rdata(s_rdata), .s00_axil_rresp(s_rresp), .s00_axil_rvalid(s_rvalid),
    .s00_axil_rready(s_rready),
    .m00_axil_awaddr(m_awaddr), .m00_axil_awprot(m_awprot), .m00_axil_awvalid(m_awvalid),
    .m00_axil_awready(m_awready), .m00_axil_wdata(m_wdata), .m00_axil_wstrb(m_wstrb),
    .m00_axil_wvalid(m_wvalid), .m00_axil_wready(m_wready), .m00_axil_bresp(m_bresp),
    .m00_axil_bvalid(m_bvalid), .m00_axil_bready(m_bready), .m00_axil_araddr(m_araddr),
    .m00_axil_arprot(m_arprot), .m00_axil_arvalid(m_arvalid), .m00_axil_arready(m_arready),
    .m00_axil_rdata(m_rdata), .m00_axil_rresp(m_rresp), .m00_axil_rvalid(m_rvalid),
    .m00_axil_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_arvalid && m_awvalid) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0; m_arready = 0;
    m_rdata = '0; m_rresp = '0; m_rvalid = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  initial begin
    int n;
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    #1;
    check("rst_vr_out", vr_out, 10'h000);
    reset_n = 1;

    // Single read
    tick();
    s_araddr = 32'h0010_0004; s_arvalid = 1; m_arready = 1; s_rready = 1;
    #1;
    check("rd_no_fwd_idle", m_arvalid, 0);
    tick(); #1;
    check("rd_arvalid", m_arvalid, 1);
    check("rd_araddr", m_araddr, 32'h0010_0004);
    check("rd_arready", s_arready, 1);
    tick();
    s_arvalid = 0; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = axil_resp_okay_gp;
    #1;
    check("rd_rvalid", s_rvalid, 1);
    check("rd_rdata", s_rdata, 32'hDEAD_BEEF);
    check("rd_rresp", s_rresp, 0);
    check("rd_ar_gated", m_arvalid, 0);
    tick();
    m_rvalid = 0;
    #1;
    check("rd_idle_vr", vr_out, 10'h000);

    // Simultaneous read and write after reset: read first
    clear_inputs();
    do_reset();
    s_araddr = 32'h0020_0000; s_arvalid = 1;
    s_awaddr = 32'h1000_0000; s_awvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1;
    m_arready = 1; m_awready = 1; m_wready = 1; s_rready = 1; s_bready = 1;
    tick(); #1;
    check("sim_ar_first", m_arvalid, 1);
    check("sim_aw_held", m_awvalid, 0);
    check("sim_w_held", m_wvalid, 0);
    check("sim_araddr", m_araddr, 32'h0020_0000);
    tick();
    s_arvalid = 0; m_rvalid = 1; m_rdata = 32'hCAFE_0001;
    #1;
    check("sim_rvalid", s_rvalid, 1);
    check("sim_aw_wait_r", m_awvalid, 0);
    tick();
    m_rvalid = 0;
    #1;
    check("sim_turnaround", m_awvalid, 0);
    tick(); #1;
    check("sim_awvalid", m_awvalid, 1);
    check("sim_wvalid", m_wvalid, 1);
    check("sim_awaddr", m_awaddr, 32'h1000_0000);
    check("sim_wdata", m_wdata, 32'h1234_5678);
    check("sim_wstrb", m_wstrb, 4'hF);
    tick();
    s_awvalid = 0; s_wvalid = 0; m_bvalid = 1; m_bresp = axil_resp_okay_gp;
    #1;
    check("sim_bvalid", s_bvalid, 1);
    check("sim_bready", m_bready, 1);
    tick();
    m_bvalid = 0;
    #1;
    check("sim_b_done", s_bvalid, 0);

    // Continuous requests alternate R,W,R,W...
    s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      #1;
      while (!(m_arvalid || m_awvalid) && n < 10) begin
        tick(); #1;
        n++;
      end
      if (n >= 10) begin
        check("rr_timeout", 1, 0);
        break;
      end
      check($sformatf("rr_order_%0d", i), m_awvalid, i % 2);
      tick();
      if (i % 2 == 1) m_bvalid = 1;
      else begin m_rvalid = 1; m_rdata = 32'hA000_0000 + i; end
      #1;
      if (i % 2 == 1) check($sformatf("rr_b_%0d", i), s_bvalid, 1);
      else check($sformatf("rr_r_%0d", i), s_rdata, 32'hA000_0000 + i);
      tick();
      m_bvalid = 0; m_rvalid = 0;
    end
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    tick();

    // Write with w 3 cycles ahead of aw and an early response
    s_awaddr = 32'h1000_0040; s_awvalid = 1; s_wdata = 32'h5555_AAAA; s_wvalid = 1;
    m_awready = 0; m_wready = 1; m_bvalid = 1; m_bresp = axil_resp_slverr_gp;
    #1;
    check("wr_idle_bready", m_bready, 0);
    tick(); #1;
    check("wr_wvalid", m_wvalid, 1);
    check("wr_awready_lo", s_awready, 0);
    check("wr_early_b", s_bvalid, 0);
    tick();
    s_wvalid = 0;
    #1;
    check("wr_w_sent_b", m_bready, 0);
    tick(); tick();
    m_awready = 1;
    #1;
    check("wr_awready", s_awready, 1);
    check("wr_b_hold", s_bvalid, 0);
    tick();
    s_awvalid = 0;
    #1;
    check("wr_bvalid", s_bvalid, 1);
    check("wr_bresp", s_bresp, 2'b10);
    check("wr_bready", m_bready, 1);
    tick();
    m_bvalid = 0;
    #1;
    check("wr_done", s_bvalid, 0);

    // Spurious rvalid in idle
    m_rvalid = 1;
    #1;
    check("sp_rready", m_rready, 0);
    check("sp_rvalid", s_rvalid, 0);
    tick(); #1;
    check("sp_vr_hold", vr_out, 10'h000);
    m_rvalid = 0;

    // Reset with read outstanding, then a fresh read
    s_araddr = 32'h0000_0030; s_arvalid = 1; m_arready = 1;
    tick(); #1;
    check("rs_ar", m_arvalid, 1);
    tick();
    s_arvalid = 0; m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
    reset_n = 0;
    #1;
    check("rs_vr_zero", vr_out, 10'h000);
    tick();
    m_rvalid = 0;
    reset_n = 1;
    tick();
    s_araddr = 32'h0000_0034; s_arvalid = 1;
    tick(); #1;
    check("rs2_ar", m_arvalid, 1);
    check("rs2_araddr", m_araddr, 32'h0000_0034);
    tick();
    s_arvalid = 0; m_rvalid = 1; m_rdata = 32'h7777_1111;
    #1;
    check("rs2_rdata", s_rdata, 32'h7777_1111);
    check("rs2_rvalid", s_rvalid, 1);
    tick();
    m_rvalid = 0;
    #1;
    check("rs2_idle", vr_out, 10'h000);

    check("no_ar_aw_overlap", overlap_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
